// File: rtl/ff_input_loader_pkg.sv
// Shared sizes and types for the feedforward input loader and its RAM-clear helpers.
package ff_input_loader_pkg;

  localparam int DEF_N_IN  = 264;
  localparam int DEF_N_H   = 64;
  localparam int DEF_N_OUT = 10;
  localparam int R_ADDR    = 9;
  localparam int SRAM_AW   = 17;
  localparam int PIX_W     = 8;
  localparam int ACC_W     = 12;

  localparam logic [SRAM_AW-1:0] ADDR_INPUT_START = 17'h1F000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Zero-fill shift keeps every scaled pixel non-negative when read as signed Q.
  function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] p, input int sh);
    return p >> sh;
  endfunction

endpackage

// File: rtl/ff_input_loader_if.sv
// Run/fin handshake, SRAM read bus and the three RAM write ports of the input loader.
interface ff_input_loader_if;
  import ff_input_loader_pkg::*;

  logic                run;
  logic                fin;
  logic [PIX_W-1:0]    sram_read_data;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [PIX_W-1:0]    sram_write_data;
  logic                sram_data_output_en;
  logic                sram_cs_n;
  logic                sram_oe_n;
  logic                sram_we_n;
  logic [PIX_W-1:0]    x_d;
  logic [R_ADDR-1:0]   x_addr;
  logic                x_we;
  logic [ACC_W-1:0]    hid_d;
  logic [R_ADDR-1:0]   hid_addr;
  logic                hid_we;
  logic [ACC_W-1:0]    out_d;
  logic [R_ADDR-1:0]   out_addr;
  logic                out_we;

  modport master (
    input  run, sram_read_data,
    output fin, sram_addr, sram_write_data, sram_data_output_en,
           sram_cs_n, sram_oe_n, sram_we_n,
           x_d, x_addr, x_we, hid_d, hid_addr, hid_we, out_d, out_addr, out_we
  );

  modport slave (
    output run, sram_read_data,
    input  fin, sram_addr, sram_write_data, sram_data_output_en,
           sram_cs_n, sram_oe_n, sram_we_n,
           x_d, x_addr, x_we, hid_d, hid_addr, hid_we, out_d, out_addr, out_we
  );

endinterface

// File: rtl/ff_input_loader_ram_zero_seq.sv
// Walks a RAM write address 0..DEPTH-1 with we high while start is held; start low clears it.
// First write one cycle after start; done is high from the last write onward; no backpressure.
module ff_input_loader_ram_zero_seq #(
  parameter int DEPTH = 64,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we     <= 1'b0;
      addr   <= '0;
      done_q <= 1'b0;
    end else if (!start) begin
      we     <= 1'b0;
      addr   <= '0;
      done_q <= 1'b0;
    end else if (we) begin
      if (addr == LAST) begin
        we     <= 1'b0;
        done_q <= 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end else if (!done_q) begin
      we   <= 1'b1;
      addr <= '0;
    end
  end

  // Counts as done as soon as the last write is on the port, so the parent can leave RUN that edge.
  assign done = done_q | (we & (addr == LAST));

endmodule

// File: rtl/ff_input_loader.sv
// Copies N_IN SRAM pixels into the x RAM (>>IN_SHIFT) while zeroing the hidden and output RAMs.
// run-to-fin latency max(N_IN+3, N_H+1, N_OUT+1)+1 cycles; no backpressure, dropping run aborts.
module ff_input_loader
  import ff_input_loader_pkg::*;
#(
  parameter int                 N_IN     = DEF_N_IN,
  parameter int                 N_H      = DEF_N_H,
  parameter int                 N_OUT    = DEF_N_OUT,
  parameter logic [SRAM_AW-1:0] IN_BASE  = ADDR_INPUT_START,
  parameter int                 IN_SHIFT = 1
) (
  input logic               clk,
  input logic               reset_n,
  ff_input_loader_if.master bus
);

  localparam logic [SRAM_AW-1:0] LAST_ADDR = SRAM_AW'(IN_BASE + N_IN - 1);
  localparam logic [R_ADDR-1:0]  X_LAST    = R_ADDR'(N_IN - 1);

  state_t state, state_nxt;
  logic   load_start, running, abort, finish;

  logic [SRAM_AW-1:0] sram_addr;
  logic               cs_n, oe_n, fin;
  logic               rd_end, pix_vld;
  logic [PIX_W-1:0]   pix;
  logic [PIX_W-1:0]   x_d;
  logic [R_ADDR-1:0]  x_addr;
  logic               x_we, x_done_q, x_done;
  logic               clr_start, hid_done, out_done;

  assign x_done    = x_done_q | (x_we & (x_addr == X_LAST));
  assign clr_start = load_start | running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    running    = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.run && !fin) begin
          load_start = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.run) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          running = 1'b1;
          if (x_done && hid_done && out_done) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr <= '0;
      cs_n      <= 1'b1;
      oe_n      <= 1'b1;
      fin       <= 1'b0;
      rd_end    <= 1'b0;
      pix_vld   <= 1'b0;
      pix       <= '0;
      x_d       <= '0;
      x_addr    <= '0;
      x_we      <= 1'b0;
      x_done_q  <= 1'b0;
    end else if (load_start) begin
      sram_addr <= IN_BASE;
      cs_n      <= 1'b0;
      oe_n      <= 1'b0;
      rd_end    <= 1'b0;
      pix_vld   <= 1'b0;
      x_addr    <= '0;
      x_we      <= 1'b0;
      x_done_q  <= 1'b0;
    end else if (running) begin
      // S0/S1: data for the address presented last cycle is valid now.
      if (!rd_end) begin
        pix     <= bus.sram_read_data;
        pix_vld <= 1'b1;
        if (sram_addr == LAST_ADDR) rd_end    <= 1'b1;
        else                        sram_addr <= sram_addr + 1'b1;
      end else begin
        pix_vld <= 1'b0;
      end
      // S2: the first write lands at index 0; later ones step the address.
      x_we <= pix_vld;
      if (pix_vld) begin
        x_d <= scale_pix(pix, IN_SHIFT);
        if (x_we) x_addr <= x_addr + 1'b1;
      end
      if (x_done) x_done_q <= 1'b1;
    end else begin
      // Idle, abort or done: no strobes, SRAM deselected.
      x_we    <= 1'b0;
      pix_vld <= 1'b0;
      cs_n    <= 1'b1;
      oe_n    <= 1'b1;
      if (finish)                 fin <= 1'b1;
      else if (abort || !bus.run) fin <= 1'b0;
    end
  end

  ff_input_loader_ram_zero_seq #(.DEPTH(N_H), .AW(R_ADDR)) u_hid_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .we      (bus.hid_we),
    .addr    (bus.hid_addr),
    .done    (hid_done)
  );

  ff_input_loader_ram_zero_seq #(.DEPTH(N_OUT), .AW(R_ADDR)) u_out_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .we      (bus.out_we),
    .addr    (bus.out_addr),
    .done    (out_done)
  );

  assign bus.fin                 = fin;
  assign bus.sram_addr           = sram_addr;
  assign bus.sram_write_data     = '0;
  assign bus.sram_data_output_en = 1'b0;
  assign bus.sram_cs_n           = cs_n;
  assign bus.sram_oe_n           = oe_n;
  assign bus.sram_we_n           = 1'b1;
  assign bus.x_d                 = x_d;
  assign bus.x_addr              = x_addr;
  assign bus.x_we                = x_we;
  assign bus.hid_d               = '0;
  assign bus.out_d               = '0;

endmodule
